des_job_sequencer: RTL

DES_JOB_SEQUENCER -- requirements
Module: des_job_sequencer

---
 rtl/des_seq_pkg.sv | 21 ++
 rtl/des_job_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/des_seq_pkg.sv
// Shared types and constants for the DES job sequencer.
package des_seq_pkg;

  localparam int unsigned ID_W_DEF   = 8;
  localparam int unsigned TO_W_DEF   = 32;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned STATUS_W   = 2;

  localparam logic [STATUS_W-1:0] STATUS_OK      = 2'b00;
  localparam logic [STATUS_W-1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [STATUS_W-1:0] STATUS_ABORTED = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESTART,
    ST_START,
    ST_RUN,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/des_job_sequencer.sv
// Accepts one job at a time, pulses restart/start into the DES block,
// waits for done/abort/timeout and holds the result until it is taken.
module des_job_sequencer
  import des_seq_pkg::*;
#(
  parameter int unsigned ID_W = ID_W_DEF,
  parameter int unsigned TO_W = TO_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [DATA_W-1:0]   job_seed,
  input  logic [DATA_W-1:0]   job_limit,
  input  logic [ID_W-1:0]     job_id,
  input  logic [TO_W-1:0]     timeout_cycles,
  input  logic                abort,
  output logic                blk_start,
  output logic                blk_restart,
  output logic [DATA_W-1:0]   blk_seed,
  output logic [DATA_W-1:0]   blk_counter_limit,
  input  logic [DATA_W-1:0]   blk_counter,
  input  logic                blk_done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ID_W-1:0]     res_id,
  output logic [DATA_W-1:0]   res_count,
  output logic [STATUS_W-1:0] res_status,
  output logic                busy
);

  state_e                state_q;
  logic                  job_ready_q;
  logic                  blk_start_q;
  logic                  blk_restart_q;
  logic [DATA_W-1:0]     blk_seed_q;
  logic [DATA_W-1:0]     blk_limit_q;
  logic                  res_valid_q;
  logic [ID_W-1:0]       res_id_q;
  logic [DATA_W-1:0]     res_count_q;
  logic [STATUS_W-1:0]   res_status_q;
  logic                  busy_q;
  logic [TO_W-1:0]       cnt_q;
  logic [TO_W-1:0]       cnt_d;

  logic                  timeout_hit_c;
  logic                  fin_c;
  logic [STATUS_W-1:0]   fin_status_c;

  // Saturating run-cycle counter and timeout compare.
  always_comb begin
    cnt_d         = (&cnt_q) ? cnt_q : cnt_q + TO_W'(1);
    timeout_hit_c = (timeout_cycles != '0) && (cnt_q == timeout_cycles - TO_W'(1));
  end

  // Job termination decision; done beats abort beats timeout, done only counts in RUN.
  always_comb begin
    fin_c        = 1'b0;
    fin_status_c = STATUS_OK;
    case (state_q)
      ST_RESTART, ST_START: begin
        if (abort) begin
          fin_c        = 1'b1;
          fin_status_c = STATUS_ABORTED;
        end
      end
      ST_RUN: begin
        if (blk_done) begin
          fin_c        = 1'b1;
          fin_status_c = STATUS_OK;
        end else if (abort) begin
          fin_c        = 1'b1;
          fin_status_c = STATUS_ABORTED;
        end else if (timeout_hit_c) begin
          fin_c        = 1'b1;
          fin_status_c = STATUS_TIMEOUT;
        end
      end
      default: begin
        fin_c        = 1'b0;
        fin_status_c = STATUS_OK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      job_ready_q   <= 1'b1;
      blk_start_q   <= 1'b0;
      blk_restart_q <= 1'b0;
      blk_seed_q    <= '0;
      blk_limit_q   <= '0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_count_q   <= '0;
      res_status_q  <= STATUS_OK;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      blk_start_q   <= 1'b0;
      blk_restart_q <= 1'b0;
      if (fin_c) begin
        res_count_q  <= blk_counter;
        res_status_q <= fin_status_c;
        res_valid_q  <= 1'b1;
        state_q      <= ST_REPORT;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (job_valid && job_ready_q) begin
              blk_seed_q    <= job_seed;
              blk_limit_q   <= job_limit;
              res_id_q      <= job_id;
              job_ready_q   <= 1'b0;
              busy_q        <= 1'b1;
              blk_restart_q <= 1'b1;
              state_q       <= ST_RESTART;
            end
          end
          ST_RESTART: begin
            blk_start_q <= 1'b1;
            state_q     <= ST_START;
          end
          ST_START: begin
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            cnt_q <= cnt_d;
          end
          ST_REPORT: begin
            if (res_ready) begin
              res_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              job_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign job_ready         = job_ready_q;
  assign blk_start         = blk_start_q;
  assign blk_restart       = blk_restart_q;
  assign blk_seed          = blk_seed_q;
  assign blk_counter_limit = blk_limit_q;
  assign res_valid         = res_valid_q;
  assign res_id            = res_id_q;
  assign res_count         = res_count_q;
  assign res_status        = res_status_q;
  assign busy              = busy_q;

endmodule
